// File: rtl/LOAD_STORE_FNS.sv
// Shared encodings and request-decoding helpers for the RV32I memory stage.
package LOAD_STORE_FNS;

  typedef enum logic [2:0] {
    F3_BYTE   = 3'b000,
    F3_HALF   = 3'b001,
    F3_WORD   = 3'b010,
    F3_BYTE_U = 3'b100,
    F3_HALF_U = 3'b101
  } funct3_t;

  localparam logic [31:0] OUTPORT_ADDR = 32'h0000_fffc;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } lsu_state_t;

  // Unsized stores and encodings with no RV32I meaning are rejected along with misalignment.
  function automatic logic access_fault(input logic       is_store,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic fault;
    case (funct3)
      F3_BYTE:   fault = 1'b0;
      F3_HALF:   fault = addr_lo[0];
      F3_WORD:   fault = |addr_lo;
      F3_BYTE_U: fault = is_store;
      F3_HALF_U: fault = is_store | addr_lo[0];
      default:   fault = 1'b1;
    endcase
    return fault;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] funct3,
                                              input logic [1:0] addr_lo);
    logic [3:0] be;
    case (funct3)
      F3_BYTE, F3_BYTE_U: be = 4'b0001 << addr_lo;
      F3_HALF, F3_HALF_U: be = 4'b0011 << {addr_lo[1], 1'b0};
      F3_WORD:            be = 4'b1111;
      default:            be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0]  funct3,
                                              input logic [31:0] wdata);
    logic [31:0] lanes;
    case (funct3)
      F3_BYTE, F3_BYTE_U: lanes = {4{wdata[7:0]}};
      F3_HALF, F3_HALF_U: lanes = {2{wdata[15:0]}};
      F3_WORD:            lanes = wdata;
      default:            lanes = '0;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Picks the addressed byte/half lane of a 32-bit word and sign- or zero-extends it.
module load_extract
  import LOAD_STORE_FNS::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr)
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];
    case (i_funct3)
      F3_BYTE:   o_value = {{24{w_byte[7]}}, w_byte};
      F3_BYTE_U: o_value = {24'd0, w_byte};
      F3_HALF:   o_value = {{16{w_half[15]}}, w_half};
      F3_HALF_U: o_value = {16'd0, w_half};
      F3_WORD:   o_value = i_word;
      default:   o_value = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: turns LOAD/STORE requests into word-aligned memory
// transactions, owns the memory-mapped output port and flags bad accesses.
module load_store_unit
  import LOAD_STORE_FNS::lsu_state_t, LOAD_STORE_FNS::IDLE, LOAD_STORE_FNS::REQ,
         LOAD_STORE_FNS::WAIT, LOAD_STORE_FNS::RESP, LOAD_STORE_FNS::access_fault,
         LOAD_STORE_FNS::byte_enables, LOAD_STORE_FNS::store_lanes;
#(
  parameter logic [31:0] OUTPORT_ADDR = LOAD_STORE_FNS::OUTPORT_ADDR,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_is_store,
  input  logic [2:0]        i_funct3,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_resp_valid,
  output logic [31:0]       o_resp_rdata,
  output logic              o_resp_fault,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-3:0] o_mem_addr,
  output logic [3:0]        o_mem_be,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_rvalid,
  input  logic [31:0]       i_mem_rdata,
  output logic [31:0]       o_outport
);

  lsu_state_t r_state;
  lsu_state_t w_state_next;

  logic              r_is_store;
  logic [2:0]        r_funct3;
  logic [1:0]        r_addr_lo;
  logic              r_resp_valid;
  logic [31:0]       r_resp_rdata;
  logic              r_resp_fault;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-3:0] r_mem_addr;
  logic [3:0]        r_mem_be;
  logic [31:0]       r_mem_wdata;
  logic [31:0]       r_outport;

  logic              w_fault;
  logic              w_outport_hit;
  logic [3:0]        w_be;
  logic [31:0]       w_lanes;
  logic [31:0]       w_ext_word;
  logic [1:0]        w_ext_addr;
  logic [2:0]        w_ext_funct3;
  logic [31:0]       w_ext_value;

  assign w_fault       = access_fault(i_is_store, i_funct3, i_addr[1:0]);
  assign w_outport_hit = (i_addr == OUTPORT_ADDR);
  assign w_be          = byte_enables(i_funct3, i_addr[1:0]);
  assign w_lanes       = store_lanes(i_funct3, i_wdata);

  // In IDLE the extractor serves an outport load straight from the live request;
  // afterwards it serves the memory word using the latched request fields.
  always_comb begin
    w_ext_word   = i_mem_rdata;
    w_ext_addr   = r_addr_lo;
    w_ext_funct3 = r_funct3;
    if (r_state == IDLE) begin
      w_ext_word   = r_outport;
      w_ext_addr   = i_addr[1:0];
      w_ext_funct3 = i_funct3;
    end
  end

  load_extract u_load_extract (
    .i_word   (w_ext_word),
    .i_addr   (w_ext_addr),
    .i_funct3 (w_ext_funct3),
    .o_value  (w_ext_value)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_req_valid) begin
          w_state_next = (w_fault || w_outport_hit) ? RESP : REQ;
        end
      end
      REQ:     w_state_next = i_mem_rvalid ? RESP : WAIT;
      WAIT: begin
        if (i_mem_rvalid) begin
          w_state_next = RESP;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_is_store   <= 1'b0;
      r_funct3     <= '0;
      r_addr_lo    <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_fault <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_be     <= '0;
      r_mem_wdata  <= '0;
      r_outport    <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_fault <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_be     <= '0;
      r_mem_wdata  <= '0;
      case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_is_store <= i_is_store;
            r_funct3   <= i_funct3;
            r_addr_lo  <= i_addr[1:0];
            if (w_fault) begin
              r_resp_valid <= 1'b1;
              r_resp_fault <= 1'b1;
            end else if (w_outport_hit) begin
              r_resp_valid <= 1'b1;
              if (i_is_store) begin
                for (int i = 0; i < 4; i++) begin
                  if (w_be[i]) begin
                    r_outport[8*i +: 8] <= w_lanes[8*i +: 8];
                  end
                end
              end else begin
                r_resp_rdata <= w_ext_value;
              end
            end else begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= i_is_store;
              r_mem_addr  <= i_addr[ADDR_W-1:2];
              r_mem_be    <= w_be;
              r_mem_wdata <= i_is_store ? w_lanes : 32'd0;
            end
          end
        end
        REQ, WAIT: begin
          if (i_mem_rvalid) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_is_store ? 32'd0 : w_ext_value;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_req_ready  = (r_state == IDLE);
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_fault = r_resp_fault;
  assign o_mem_req    = r_mem_req;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_be     = r_mem_be;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_outport    = r_outport;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a cycle-indexed behavioural model
// of request timing, byte lanes, extension and the output-port register.
module tb_load_store_unit;
  import LOAD_STORE_FNS::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_is_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_resp_valid;
  logic [31:0] o_resp_rdata;
  logic        o_resp_fault;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [29:0] o_mem_addr;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_wdata;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic [31:0] o_outport;

  load_store_unit dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_is_store   (i_is_store),
    .i_funct3     (i_funct3),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .o_resp_valid (o_resp_valid),
    .o_resp_rdata (o_resp_rdata),
    .o_resp_fault (o_resp_fault),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_be     (o_mem_be),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata),
    .o_outport    (o_outport)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Model expectations, indexed by the cycle counter value seen after each edge.
  int          e_acc = -100;
  int          e_req = -100;
  int          e_resp = -100;
  logic        exp_we;
  logic [31:0] exp_maddr;
  logic [3:0]  exp_be;
  logic [31:0] exp_wd;
  logic [31:0] exp_rdata;
  logic        exp_fault;
  logic [31:0] mdl_outport = 32'd0;
  bit          chk_en = 1'b0;

  int          req_count = 0;
  int          last_req_cyc;
  int          last_resp_cyc;
  logic [31:0] last_rdata;
  logic [31:0] last_maddr;
  logic [31:0] last_wd;
  logic [3:0]  last_be;
  logic        last_we;
  logic        last_fault;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int mdl_size(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit mdl_fault(input bit st, input logic [2:0] f3, input logic [31:0] a);
    bit bad_code;
    bit bad_store;
    bit bad_align;
    bad_code  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    bad_store = st && (f3 == 3'd4 || f3 == 3'd5);
    bad_align = (int'(a[1:0]) % mdl_size(f3)) != 0;
    return bad_code || bad_store || bad_align;
  endfunction

  function automatic logic [3:0] mdl_be(input logic [2:0] f3, input logic [31:0] a);
    logic [7:0] m;
    m = ((8'd1 << mdl_size(f3)) - 8'd1) << a[1:0];
    return m[3:0];
  endfunction

  function automatic logic [31:0] mdl_repl(input logic [2:0] f3, input logic [31:0] wd);
    if (mdl_size(f3) == 1) return {24'd0, wd[7:0]} * 32'h0101_0101;
    if (mdl_size(f3) == 2) return {16'd0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] mdl_extract(input logic [31:0] word, input logic [31:0] a,
                                              input logic [2:0] f3);
    int          sz;
    logic [31:0] v;
    logic [31:0] mask;
    sz = mdl_size(f3);
    if (sz == 4) return word;
    v    = word >> (8 * a[1:0]);
    mask = (32'd1 << (8 * sz)) - 32'd1;
    v    = v & mask;
    if (!f3[2] && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  // Single compare process: every cycle, every output against the model.
  always @(posedge clk) begin
    #1;
    if (chk_en && !rst) begin
      checkOutput("req_ready", 32'(o_req_ready), 32'(!(cyc >= e_acc && cyc <= e_resp)));
      checkOutput("mem_req", 32'(o_mem_req), 32'(cyc == e_req));
      if (o_mem_req) begin
        req_count++;
        last_req_cyc = cyc;
        last_we      = o_mem_we;
        last_maddr   = 32'(o_mem_addr);
        last_be      = o_mem_be;
        last_wd      = o_mem_wdata;
      end
      if (cyc == e_req) begin
        checkOutput("mem_we", 32'(o_mem_we), 32'(exp_we));
        checkOutput("mem_addr", 32'(o_mem_addr), exp_maddr);
        checkOutput("mem_be", 32'(o_mem_be), 32'(exp_be));
        checkOutput("mem_wdata", o_mem_wdata, exp_wd);
      end
      checkOutput("resp_valid", 32'(o_resp_valid), 32'(cyc == e_resp));
      if (o_resp_valid) begin
        last_resp_cyc = cyc;
        last_rdata    = o_resp_rdata;
        last_fault    = o_resp_fault;
      end
      if (cyc == e_resp) begin
        checkOutput("resp_rdata", o_resp_rdata, exp_rdata);
        checkOutput("resp_fault", 32'(o_resp_fault), 32'(exp_fault));
      end
      checkOutput("outport", o_outport, mdl_outport);
    end
  end

  task automatic applyStimulus(input bit st, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input int k, input logic [31:0] rd,
                               input bit hold);
    int          guard;
    bit          flt;
    bit          outp;
    logic [31:0] rp;
    logic [3:0]  be;
    guard = 0;
    while (o_req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) checkOutput("ready_wait", 32'(o_req_ready), 32'd1);
    flt  = mdl_fault(st, f3, a);
    outp = !flt && (a == OUTPORT_ADDR);
    last_req_cyc  = -1;
    last_resp_cyc = -1;
    last_rdata    = 32'hDEAD_0001;
    last_fault    = 1'bx;
    e_acc = cyc + 1;
    if (flt || outp) begin
      e_req  = -100;
      e_resp = e_acc;
    end else begin
      e_req  = e_acc;
      e_resp = e_acc + k + 1;
    end
    exp_we    = st;
    exp_maddr = {2'b00, a[31:2]};
    exp_be    = mdl_be(f3, a);
    exp_wd    = st ? mdl_repl(f3, wd) : 32'd0;
    exp_fault = flt;
    if (flt || st) exp_rdata = 32'd0;
    else if (outp) exp_rdata = mdl_extract(mdl_outport, a, f3);
    else           exp_rdata = mdl_extract(rd, a, f3);
    i_req_valid = 1'b1;
    i_is_store  = st;
    i_funct3    = f3;
    i_addr      = a;
    i_wdata     = wd;
    @(posedge clk);
    if (outp && st) begin
      rp = mdl_repl(f3, wd);
      be = mdl_be(f3, a);
      for (int i = 0; i < 4; i++) if (be[i]) mdl_outport[8*i +: 8] = rp[8*i +: 8];
    end
    @(negedge clk);
    i_req_valid = 1'b0;
    i_is_store  = 1'($urandom);
    i_funct3    = 3'($urandom);
    i_addr      = $urandom;
    i_wdata     = $urandom;
    if (!flt && !outp) begin
      repeat (k) @(negedge clk);
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = rd;
      @(negedge clk);
      i_mem_rvalid = hold;
      i_mem_rdata  = $urandom;
    end
    while (cyc <= e_resp) @(negedge clk);
    i_mem_rvalid = 1'b0;
  endtask

  initial begin
    int          base_req;
    int          pick;
    logic [31:0] a;
    rst          = 1'b1;
    i_req_valid  = 1'b0;
    i_is_store   = 1'b0;
    i_funct3     = 3'd0;
    i_addr       = 32'd0;
    i_wdata      = 32'd0;
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = 32'd0;
    repeat (2) @(negedge clk);
    checkOutput("reset_req_ready", 32'(o_req_ready), 32'd1);
    checkOutput("reset_resp_valid", 32'(o_resp_valid), 32'd0);
    checkOutput("reset_mem_req", 32'(o_mem_req), 32'd0);
    checkOutput("reset_outport", o_outport, 32'd0);
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    checkOutput("model_lb", mdl_extract(32'h8012_3456, 32'h103, 3'b000), 32'hFFFF_FF80);
    checkOutput("model_lhu", mdl_extract(32'hBEEF_1234, 32'h102, 3'b101), 32'h0000_BEEF);
    checkOutput("model_be_sh", 32'(mdl_be(3'b001, 32'h22)), 32'h0000_000C);

    applyStimulus(1'b0, 3'b000, 32'h103, 32'd0, 1, 32'h8012_3456, 1'b0);
    checkOutput("lb_rdata", last_rdata, 32'hFFFF_FF80);
    checkOutput("lb_mem_be", 32'(last_be), 32'h8);
    checkOutput("lb_mem_addr", last_maddr, 32'h40);
    checkOutput("lb_latency", 32'(last_resp_cyc - e_acc), 32'd2);
    applyStimulus(1'b0, 3'b100, 32'h103, 32'd0, 1, 32'h8012_3456, 1'b0);
    checkOutput("lbu_rdata", last_rdata, 32'h0000_0080);
    applyStimulus(1'b0, 3'b101, 32'h102, 32'd0, 0, 32'hBEEF_1234, 1'b1);
    checkOutput("lhu_rdata", last_rdata, 32'h0000_BEEF);
    applyStimulus(1'b1, 3'b001, 32'h22, 32'h1234_ABCD, 2, 32'h5555_5555, 1'b0);
    checkOutput("sh_we", 32'(last_we), 32'd1);
    checkOutput("sh_be", 32'(last_be), 32'hC);
    checkOutput("sh_wdata", last_wd, 32'hABCD_ABCD);
    checkOutput("sh_rdata", last_rdata, 32'd0);
    checkOutput("sh_fault", 32'(last_fault), 32'd0);

    base_req = req_count;
    applyStimulus(1'b1, 3'b010, 32'h0000_fffc, 32'hDEAD_BEEF, 0, 32'd0, 1'b0);
    checkOutput("sw_outport", o_outport, 32'hDEAD_BEEF);
    checkOutput("sw_outport_latency", 32'(last_resp_cyc - e_acc), 32'd0);
    applyStimulus(1'b0, 3'b010, 32'h0000_fffc, 32'd0, 0, 32'd0, 1'b0);
    checkOutput("lw_outport_rdata", last_rdata, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 3'b010, 32'h102, 32'd0, 0, 32'd0, 1'b0);
    checkOutput("lw_misaligned_fault", 32'(last_fault), 32'd1);
    checkOutput("lw_misaligned_latency", 32'(last_resp_cyc - e_acc), 32'd0);
    applyStimulus(1'b1, 3'b100, 32'h0000_fffc, 32'h1111_2222, 0, 32'd0, 1'b0);
    checkOutput("store_f3_100_fault", 32'(last_fault), 32'd1);
    checkOutput("no_mem_req_outport_or_fault", 32'(req_count - base_req), 32'd0);
    checkOutput("fault_outport_kept", o_outport, 32'hDEAD_BEEF);

    for (int n = 0; n < 300; n++) begin
      pick = int'($urandom_range(0, 3));
      if (pick == 0)      a = OUTPORT_ADDR;
      else if (pick == 1) a = OUTPORT_ADDR + 32'($urandom_range(1, 3));
      else                a = $urandom;
      applyStimulus(1'($urandom), 3'($urandom), a, $urandom, int'($urandom_range(0, 3)),
                    $urandom, 1'($urandom));
      repeat ($urandom_range(0, 2)) begin
        i_mem_rvalid = 1'($urandom);
        i_mem_rdata  = $urandom;
        @(negedge clk);
      end
      i_mem_rvalid = 1'b0;
    end

    applyStimulus(1'b1, 3'b010, 32'h0000_fffc, 32'h5A5A_0F0F, 0, 32'd0, 1'b0);
    e_acc       = cyc + 1;
    e_req       = e_acc;
    e_resp      = e_acc + 1000;
    exp_we      = 1'b0;
    exp_maddr   = 32'h80;
    exp_be      = 4'hF;
    exp_wd      = 32'd0;
    i_req_valid = 1'b1;
    i_is_store  = 1'b0;
    i_funct3    = 3'b010;
    i_addr      = 32'h200;
    @(negedge clk);
    i_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_wait_ready", 32'(o_req_ready), 32'd1);
    checkOutput("rst_wait_resp_valid", 32'(o_resp_valid), 32'd0);
    checkOutput("rst_wait_mem_req", 32'(o_mem_req), 32'd0);
    checkOutput("rst_wait_mem_be", 32'(o_mem_be), 32'd0);
    checkOutput("rst_wait_mem_addr", 32'(o_mem_addr), 32'd0);
    checkOutput("rst_wait_outport", o_outport, 32'd0);
    @(negedge clk);
    rst          = 1'b0;
    mdl_outport  = 32'd0;
    e_acc        = -100;
    e_req        = -100;
    e_resp       = -100;
    chk_en       = 1'b1;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'hFFFF_FFFF;
    @(negedge clk);
    i_mem_rvalid = 1'b0;
    repeat (4) @(negedge clk);
    applyStimulus(1'b0, 3'b001, 32'h3006, 32'd0, 3, 32'h8001_7FFF, 1'b0);
    checkOutput("post_reset_lh", last_rdata, 32'hFFFF_8001);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
